// File: rtl/decode_skid_buffer.sv
// decode_skid_buffer
//   Two-entry skid buffer between the decoder and the rename stage. The
//   decoder-facing ready is a function of registered state only, so no
//   combinational ready path crosses the stage. Rename back-pressure is
//   absorbed by a skid entry, and a flush discards everything held.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_flush         discard held and incoming micro-ops this cycle
//   i_valid/o_ready decoder-side handshake, i_uop payload
//   o_valid/i_ready rename-side handshake, o_uop head payload
//   o_count         entries held (0..2)
//   o_stall_cycles  saturating count of cycles the head was blocked by rename
module decode_skid_buffer #(
  parameter int XLEN  = 32,
  parameter int UOP_W = 2*XLEN+23,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [UOP_W-1:0] i_uop,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [UOP_W-1:0] o_uop,
  output logic [1:0]       o_count,
  output logic [CNT_W-1:0] o_stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [UOP_W-1:0] main_q, main_nxt;
  logic [UOP_W-1:0] skid_q, skid_nxt;
  logic [CNT_W-1:0] stall_q;
  logic             in_fire, out_fire;

  // Handshake outputs look only at state, flush and reset.
  assign o_valid  = (state != EMPTY) & ~i_flush;
  assign o_ready  = (state != FULL) & ~i_flush & rst_n;
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  assign o_uop          = main_q;
  assign o_count        = state;
  assign o_stall_cycles = stall_q;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (i_flush) begin
      state_nxt = EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = BUSY;
            main_nxt  = i_uop;
          end
        end
        BUSY: begin
          if (in_fire && !out_fire) begin
            state_nxt = FULL;
            skid_nxt  = i_uop;
          end else if (out_fire && !in_fire) begin
            state_nxt = EMPTY;
          end else if (in_fire && out_fire) begin
            main_nxt = i_uop;
          end
        end
        FULL: begin
          // o_ready is low here, so only the drain side can fire.
          if (out_fire) begin
            state_nxt = BUSY;
            main_nxt  = skid_q;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = '0;
          skid_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  // Stall counter survives flushes; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state != EMPTY) && !i_ready && !i_flush && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_skid_buffer.sv
module tb_decode_skid_buffer;

  localparam int XLEN  = 32;
  localparam int UOP_W = 2*XLEN+23;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  logic [UOP_W-1:0] i_uop;
  logic             o_valid;
  logic             i_ready;
  logic [UOP_W-1:0] o_uop;
  logic [1:0]       o_count;
  logic [CNT_W-1:0] o_stall_cycles;

  int checks = 0;
  int errors = 0;

  // Bench-side model: expected occupancy, scoreboard of accepted uops, stall count.
  logic [UOP_W-1:0] sb[$];
  int               mcnt   = 0;
  int               mstall = 0;

  decode_skid_buffer #(
    .XLEN (XLEN),
    .UOP_W(UOP_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_flush       (i_flush),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_uop         (i_uop),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_uop         (o_uop),
    .o_count       (o_count),
    .o_stall_cycles(o_stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [UOP_W-1:0] mk(input logic [XLEN-1:0] pc);
    logic [22:0] lo;
    lo = pc[22:0] ^ 23'h5A5A5;
    return {pc, pc ^ 32'hA5A5_0000, lo};
  endfunction

  task automatic check(input string tag, input logic [UOP_W-1:0] obs, input logic [UOP_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle against the model,
  // pop the scoreboard on an expected drain, then advance the model.
  task automatic step(input logic v, input logic [UOP_W-1:0] u, input logic r, input logic f);
    logic ev, er, inf, outf;
    logic [UOP_W-1:0] exp_uop;
    i_valid = v;
    i_uop   = u;
    i_ready = r;
    i_flush = f;
    @(negedge clk);
    ev = (mcnt != 0) && !f;
    er = (mcnt != 2) && !f;
    check("o_valid", o_valid, ev);
    check("o_ready", o_ready, er);
    check("o_count", o_count, mcnt);
    check("o_stall_cycles", o_stall_cycles, mstall);
    outf = ev & r;
    inf  = v & er;
    if (outf) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow observed=empty expected=entry");
      end
      if (sb.size() != 0) begin
        exp_uop = sb.pop_front();
        check("o_uop", o_uop, exp_uop);
      end
    end
    if ((mcnt != 0) && !r && !f && (mstall != 15)) mstall++;
    if (f) begin
      mcnt = 0;
      sb.delete();
    end else begin
      if (inf) sb.push_back(u);
      mcnt = mcnt + int'(inf) - int'(outf);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_uop   = '0;
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_ready", o_ready, 0);
    check("rst_o_count", o_count, 0);
    check("rst_o_uop", o_uop, 0);
    check("rst_stall", o_stall_cycles, 0);
    #11;
    rst_n = 1'b1;
    #1;
    check("rel_o_ready", o_ready, 1);
    @(posedge clk);
    #1;

    // Streaming at full rate.
    step(1'b1, mk(32'h100), 1'b1, 1'b0);
    step(1'b1, mk(32'h104), 1'b1, 1'b0);
    step(1'b1, mk(32'h108), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Back-pressure: fill, refuse a third push, then drain in order.
    step(1'b1, mk(32'h200), 1'b0, 1'b0);
    step(1'b1, mk(32'h204), 1'b0, 1'b0);
    step(1'b1, mk(32'h208), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush while full with both sides attempting to transfer.
    step(1'b1, mk(32'h500), 1'b0, 1'b0);
    step(1'b1, mk(32'h504), 1'b0, 1'b0);
    step(1'b1, mk(32'h508), 1'b1, 1'b1);
    check("flush_o_uop", o_uop, 0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Simultaneous accept and drain in BUSY.
    step(1'b1, mk(32'h300), 1'b1, 1'b0);
    step(1'b1, mk(32'h304), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset while full.
    step(1'b1, mk(32'h600), 1'b0, 1'b0);
    step(1'b1, mk(32'h604), 1'b0, 1'b0);
    check("full_o_count", o_count, 2);
    i_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("arst_o_valid", o_valid, 0);
    check("arst_o_ready", o_ready, 0);
    check("arst_o_count", o_count, 0);
    check("arst_o_uop", o_uop, 0);
    mcnt   = 0;
    mstall = 0;
    sb.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("arel_o_ready", o_ready, 1);
    @(posedge clk);
    #1;
    step(1'b1, mk(32'h400), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Stall counter saturation with one entry held.
    step(1'b1, mk(32'h700), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
    check("stall_saturated", o_stall_cycles, 15);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_skid_buffer.md
Name: decode_skid_buffer

Overview:
- Two-entry skid buffer and handshake controller between the decoder and the rename stage.
- Captures the decoder's micro-op bundle and paces the decoder with a registered ready, so no combinational ready path crosses the stage.
- Absorbs rename back-pressure without losing an instruction.
- Flushes all held micro-ops on a branch mispredict or redirect.

Parameters:
- XLEN, 32: width of PC and immediate.
- UOP_W, 2*XLEN+23: packed micro-op width (87 at default).
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- i_flush  input  1  discard all held and incoming micro-ops this cycle.
- i_valid  input  1  decoder has a micro-op.
- o_ready  output  1  buffer can accept (to decoder).
- i_uop  input  UOP_W  decoder micro-op.
- o_valid  output  1  micro-op available to rename.
- i_ready  input  1  rename accepts.
- o_uop  output  UOP_W  head micro-op.
- o_count  output  2  entries held (0..2).
- o_stall_cycles  output  CNT_W  cycles the head was blocked by rename.

Behaviour:
- uop packing, MSB to LSB: pc[XLEN], immediate[XLEN], rs1[5], rs2[5], rd[5], ALUOp[2], ALUsrc, Branch, FUtype, Memread, Memwrite, Regwrite. The block never interprets these fields.
- Storage: main register (the head, drives o_uop) and skid register. States are EMPTY (0 entries), BUSY (1), FULL (2). o_count is 0/1/2 for these states.
- in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
- o_valid = (state != EMPTY) & ~i_flush.
- o_ready = (state != FULL) & ~i_flush & rst_n.
- Both outputs depend only on state, i_flush and rst_n, never on i_ready or i_valid.
- State transitions:
  - EMPTY: in_fire -> BUSY, main <= i_uop.
  - BUSY: in_fire & ~out_fire -> FULL, skid <= i_uop.
  - BUSY: out_fire & ~in_fire -> EMPTY.
  - BUSY: in_fire & out_fire -> BUSY, main <= i_uop.
  - FULL: out_fire -> BUSY, main <= skid. in_fire is impossible because o_ready = 0.
  - No fire in a state: hold state and registers.
- Ordering is strict FIFO. Every accepted micro-op is presented exactly once unless flushed.
- Latency: one cycle from in_fire to o_valid. The buffer sustains 1 micro-op/cycle when i_ready is held high.
- Flush:
  - i_flush masks o_valid and o_ready in the same cycle, so no transfer happens on either side.
  - Next state is EMPTY and main/skid clear to 0.
  - Flush overrides every simultaneous event.
- Stall counter:
  - Increments when (state != EMPTY) & ~i_ready & ~i_flush.
  - Saturates at all-ones.
  - Cleared by reset only; flush does not clear it.
- Reset (asynchronous, rst_n low):
  - State EMPTY; main, skid, o_uop and o_stall_cycles = 0.
  - o_valid = 0, o_ready = 0, o_count = 0.
  - o_ready rises to 1 in the first cycle after rst_n deasserts.
- Reset asserted mid-operation drops all held micro-ops immediately, with no partial state.
- o_uop is don't-care for consumers when o_valid = 0, but it is 0 after reset or flush until the next capture.

Test Plan:
- Streaming: i_ready = 1; push pc 0x100, 0x104, 0x108 back-to-back -> o_valid each following cycle, same order, o_count stays 1, o_ready stays 1, stall counter 0.
- Back-pressure: i_ready = 0; push 0x200 then 0x204 -> o_count 2, o_ready 0, a third push is not accepted; raise i_ready -> 0x200 then 0x204 out on consecutive cycles, o_stall_cycles equals the blocked-cycle count.
- Flush while FULL with i_valid = 1 and i_ready = 1 -> that cycle o_valid = 0 and o_ready = 0; next cycle o_count 0, o_uop 0, o_ready 1; stall counter unchanged.
- Simultaneous in/out in BUSY with head 0x300, input 0x304 -> 0x300 consumed, head becomes 0x304, o_count stays 1.
- Async reset asserted while FULL -> o_valid, o_ready and o_count drop to 0 without a clock edge; after release, o_ready = 1 next cycle and a push of 0x400 yields o_valid with 0x400.
- Counter saturation with CNT_W = 4: hold i_ready = 0 for 20 cycles with one entry -> o_stall_cycles stops at 15.
